// File: rtl/rv_mtimer_pkg.sv
// Shared types and register map for the rv_mtimer machine timer.
package rv_mtimer_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned MTIME_W = 64;
  localparam int unsigned PCNT_W  = 8;
  localparam int unsigned ADDR_W  = 2;

  typedef logic [MTIME_W-1:0] mtime_t;
  typedef logic [ADDR_W-1:0]  reg_addr_t;
  typedef logic [XLEN-1:0]    word_t;

  localparam reg_addr_t MTIME_LO    = 2'd0;
  localparam reg_addr_t MTIME_HI    = 2'd1;
  localparam reg_addr_t MTIMECMP_LO = 2'd2;
  localparam reg_addr_t MTIMECMP_HI = 2'd3;

  localparam mtime_t MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Word view of a 64-bit register for the read mux.
  function automatic word_t word_of(mtime_t val, logic hi);
    return hi ? val[MTIME_W-1:XLEN] : val[XLEN-1:0];
  endfunction

endpackage

// File: rtl/tick_edge.sv
// Rising-edge detector with async reset; suppresses a rise in the first cycle after reset.
module tick_edge (
  input  logic clk_in,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_c
);

  logic sig_q;
  logic armed_q;

  // armed_q blocks a level that is already high at reset release from counting as an edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sig_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sig_q   <= sig_i;
      armed_q <= 1'b1;
    end
  end

  assign rise_c = sig_i & ~sig_q & armed_q;

endmodule

// File: rtl/rv_mtimer.sv
// RISC-V machine timer: prescaled mtime, mtimecmp compare and 32-bit word register port.
// Optional halt input enabled by defining RV_MTIMER_HALT_EN.
module rv_mtimer
  import rv_mtimer_pkg::*;
#(
  parameter int unsigned PRESCALE     = 1,
  parameter mtime_t      MTIMECMP_RST = rv_mtimer_pkg::MTIMECMP_RST
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              tick_src,
`ifdef RV_MTIMER_HALT_EN
  input  logic              halt,
`endif
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wr_data,
  output logic [XLEN-1:0]   rd_data,
  output logic              rd_valid,
  output logic              mtip
);

  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

  logic              tick_rise_c;
  logic              run_c;
  logic              inc_c;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  mtime_t            mtime_q, mtime_d;
  mtime_t            mtimecmp_q, mtimecmp_d;
  word_t             rd_data_q, rd_data_d;
  logic              rd_valid_q;
  logic              mtip_q;

  tick_edge u_tick_edge (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .sig_i  (tick_src),
    .rise_c (tick_rise_c)
  );

`ifdef RV_MTIMER_HALT_EN
  assign run_c = tick_rise_c & ~halt;
`else
  assign run_c = tick_rise_c;
`endif

  // Prescaler: one inc per PRESCALE rising edges of tick_src.
  always_comb begin
    pcnt_d = pcnt_q;
    inc_c  = 1'b0;
    if (run_c) begin
      if (pcnt_q == PCNT_LAST) begin
        pcnt_d = '0;
        inc_c  = 1'b1;
      end else begin
        pcnt_d = pcnt_q + PCNT_W'(1);
      end
    end
  end

  // A write to an mtime half overrides a coincident increment.
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    if (inc_c) begin
      mtime_d = mtime_q + MTIME_W'(1);
    end
    if (wr_en) begin
      unique case (addr)
        MTIME_LO:    mtime_d    = {mtime_q[MTIME_W-1:XLEN], wr_data};
        MTIME_HI:    mtime_d    = {wr_data, mtime_q[XLEN-1:0]};
        MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[MTIME_W-1:XLEN], wr_data};
        MTIMECMP_HI: mtimecmp_d = {wr_data, mtimecmp_q[XLEN-1:0]};
        default:     ;
      endcase
    end
  end

  // Read mux samples pre-write register values.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      unique case (addr)
        MTIME_LO:    rd_data_d = word_of(mtime_q, 1'b0);
        MTIME_HI:    rd_data_d = word_of(mtime_q, 1'b1);
        MTIMECMP_LO: rd_data_d = word_of(mtimecmp_q, 1'b0);
        MTIMECMP_HI: rd_data_d = word_of(mtimecmp_q, 1'b1);
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q     <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RST;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      mtip_q     <= 1'b0;
    end else begin
      pcnt_q     <= pcnt_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
      mtip_q     <= (mtime_q >= mtimecmp_q);
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign mtip     = mtip_q;

endmodule

// File: tb/tb_rv_mtimer.sv
// Self-checking bench for rv_mtimer: PRESCALE=1 and PRESCALE=4 instances share stimulus.
module tb_rv_mtimer;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        tick_src;
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data1, rd_data4;
  logic        rd_valid1, rd_valid4;
  logic        mtip1, mtip4;
`ifdef RV_MTIMER_HALT_EN
  logic        halt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e4;
    string       nm;
  } rd_exp_t;

  typedef struct {
    logic        wr;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] e1;
    logic [31:0] e4;
  } vec_t;

  rd_exp_t rdq[$];

  always #5 clk_in = ~clk_in;

  rv_mtimer #(.PRESCALE(1)) u_dut1 (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .tick_src (tick_src),
`ifdef RV_MTIMER_HALT_EN
    .halt     (halt),
`endif
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data1),
    .rd_valid (rd_valid1),
    .mtip     (mtip1)
  );

  rv_mtimer #(.PRESCALE(4)) u_dut4 (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .tick_src (tick_src),
`ifdef RV_MTIMER_HALT_EN
    .halt     (halt),
`endif
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data4),
    .rd_valid (rd_valid4),
    .mtip     (mtip4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e1, input logic [31:0] e4,
                    input string nm);
    rdq.push_back('{e1, e4, nm});
    addr = a; rd_en = 1'b1;
    step();
    chk({nm, "_vld_hi"}, 64'(rd_valid1 & rd_valid4), 64'd1);
    rd_en = 1'b0;
    step();
    chk({nm, "_vld_lo"}, 64'(rd_valid1 | rd_valid4), 64'd0);
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      tick_src = 1'b1; step(); step();
      tick_src = 1'b0; step(); step();
    end
  endtask

  // Scoreboard: every read-valid pulse pops the oldest expected read.
  always @(negedge clk_in) begin
    if (rd_valid1 || rd_valid4) begin
      if (rdq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_rd_valid: got 1 expected 0");
      end else begin
        rd_exp_t r;
        r = rdq.pop_front();
        chk({r.nm, "_p1"}, 64'(rd_data1), 64'(r.e1));
        chk({r.nm, "_p4"}, 64'(rd_data4), 64'(r.e4));
      end
    end
  end

  initial begin
    vec_t vt[8];
    vt[0] = '{1'b0, 2'd0, 32'h0,           32'd5,           32'd1};
    vt[1] = '{1'b0, 2'd2, 32'h0,           32'd100,         32'd100};
    vt[2] = '{1'b1, 2'd2, 32'hDEAD_BEEF,   32'hDEAD_BEEF,   32'hDEAD_BEEF};
    vt[3] = '{1'b1, 2'd3, 32'h1234_5678,   32'h1234_5678,   32'h1234_5678};
    vt[4] = '{1'b0, 2'd2, 32'h0,           32'hDEAD_BEEF,   32'hDEAD_BEEF};
    vt[5] = '{1'b1, 2'd1, 32'h0000_0002,   32'd2,           32'd2};
    vt[6] = '{1'b0, 2'd0, 32'h0,           32'd5,           32'd1};
    vt[7] = '{1'b1, 2'd1, 32'h0,           32'd0,           32'd0};

    rst_n = 1'b0; tick_src = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    addr = 2'd0; wr_data = 32'd0;
`ifdef RV_MTIMER_HALT_EN
    halt = 1'b0;
`endif
    repeat (3) step();
    chk("rst_rd_data", {rd_data1, rd_data4}, 64'd0);
    chk("rst_rd_valid", 64'({rd_valid1, rd_valid4}), 64'd0);
    chk("rst_mtip", 64'({mtip1, mtip4}), 64'd0);
    rst_n = 1'b1;
    step(); step();

    // Ten edges at PRESCALE=1 and PRESCALE=4
    edges(10);
    rd(2'd0, 32'd10, 32'd2, "ten_lo");
    rd(2'd1, 32'd0, 32'd0, "ten_hi");
    chk("ten_mtip", 64'({mtip1, mtip4}), 64'd0);
    edges(2);
    rd(2'd0, 32'd12, 32'd3, "twelve_lo");
    edges(3);
    rd(2'd0, 32'd15, 32'd3, "fifteen_lo");
    edges(1);
    rd(2'd0, 32'd16, 32'd4, "sixteen_lo");

    // Compare: mtimecmp=5, mtip rises 2 cycles after the 5th edge
    wr(2'd0, 32'd0); wr(2'd1, 32'd0);
    wr(2'd2, 32'd5); wr(2'd3, 32'd0);
    step();
    chk("cmp5_pre_mtip", 64'({mtip1, mtip4}), 64'd0);
    edges(4);
    tick_src = 1'b1; step();
    chk("cmp5_n1_mtip", 64'(mtip1), 64'd0);
    step();
    chk("cmp5_n2_mtip", 64'(mtip1), 64'd1);
    chk("cmp5_p4_mtip", 64'(mtip4), 64'd0);
    tick_src = 1'b0; step(); step();
    wr(2'd2, 32'd100);
    chk("cmp100_n1_mtip", 64'(mtip1), 64'd1);
    step();
    chk("cmp100_n2_mtip", 64'(mtip1), 64'd0);

    // Table: write/read-back of register words
    for (int i = 0; i < 8; i++) begin
      if (vt[i].wr) wr(vt[i].a, vt[i].d);
      rd(vt[i].a, vt[i].e1, vt[i].e4, $sformatf("vec%0d", i));
    end
    chk("vec_mtip", 64'({mtip1, mtip4}), 64'd0);

    // Read during write to the same word returns the old value
    rdq.push_back('{32'h1234_5678, 32'h1234_5678, "rdw"});
    addr = 2'd3; wr_data = 32'hFFFF_FFFF; wr_en = 1'b1; rd_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    step();
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "rdw_after");

    // Wrap from all-ones to zero
    wr(2'd0, 32'hFFFF_FFFF); wr(2'd1, 32'hFFFF_FFFF);
    step();
    chk("wrap_pre_mtip", 64'({mtip1, mtip4}), 64'h3);
    tick_src = 1'b1; step();
    chk("wrap_n1_mtip", 64'(mtip1), 64'd1);
    step();
    chk("wrap_n2_mtip", 64'({mtip1, mtip4}), 64'h1);
    tick_src = 1'b0; step(); step();
    rd(2'd0, 32'd0, 32'hFFFF_FFFF, "wrap_lo");
    rd(2'd1, 32'd0, 32'hFFFF_FFFF, "wrap_hi");

    // Write coincident with an increment wins
    addr = 2'd0; wr_data = 32'd7; wr_en = 1'b1; tick_src = 1'b1;
    step();
    wr_en = 1'b0; step();
    tick_src = 1'b0; step(); step();
    rd(2'd0, 32'd7, 32'd7, "coll7_lo");
    addr = 2'd0; wr_data = 32'd20; wr_en = 1'b1; tick_src = 1'b1;
    step();
    wr_en = 1'b0; step();
    tick_src = 1'b0; step(); step();
    edges(1);
    rd(2'd0, 32'd21, 32'd20, "coll20_lo");
    rd(2'd1, 32'd0, 32'hFFFF_FFFF, "coll20_hi");

    // Reset mid-count with tick_src held high
    tick_src = 1'b1; step(); step();
    rst_n = 1'b0; step();
    chk("mid_rst_rd_data", {rd_data1, rd_data4}, 64'd0);
    chk("mid_rst_mtip", 64'({mtip1, mtip4, rd_valid1, rd_valid4}), 64'd0);
    rst_n = 1'b1;
    step(); step(); step();
    rd(2'd0, 32'd0, 32'd0, "post_rst_lo");
    tick_src = 1'b0; step(); step();
    edges(1);
    rd(2'd0, 32'd1, 32'd0, "post_rst_edge_lo");
    chk("post_rst_mtip", 64'({mtip1, mtip4}), 64'd0);

`ifdef RV_MTIMER_HALT_EN
    halt = 1'b1;
    edges(5);
    rd(2'd0, 32'd1, 32'd0, "halt_lo");
    halt = 1'b0;
    edges(1);
    rd(2'd0, 32'd2, 32'd0, "unhalt_lo");
`endif

    step();
    chk("rdq_drained", 64'(rdq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv_mtimer.md
# rv_mtimer

RISC-V machine timer consuming the divided clock from the clock divider as a rate reference. Samples `tick_src` (the divider output, generated from the same `clk_in`) and advances a 64-bit `mtime` once per `PRESCALE` rising edges. Compares `mtime` against a 64-bit `mtimecmp` and raises the machine timer interrupt to the core. Exposes a 32-bit word register interface.

## Interface
- `PRESCALE`, 1: `tick_src` rising edges per `mtime` increment; legal range 1..255.
- `MTIMECMP_RST`, 64'hFFFF_FFFF_FFFF_FFFF: reset value of `mtimecmp`.
- `clk_in`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick_src`  in  1  divided clock from the divider; synchronous to `clk_in`, so no synchronizer.
- `wr_en`  in  1  register write strobe.
- `rd_en`  in  1  register read strobe.
- `addr`  in  2  word select: 0 `mtime[31:0]`, 1 `mtime[63:32]`, 2 `mtimecmp[31:0]`, 3 `mtimecmp[63:32]`.
- `wr_data`  in  32  write data.
- `rd_data`  out  32  registered read data.
- `rd_valid`  out  1  `rd_data` valid; one-cycle pulse.
- `mtip`  out  1  machine timer interrupt pending; level, registered.

## Operation
- Edge detect: `tick_q` <= `tick_src` each cycle. `edge` = `tick_src & ~tick_q`.
- Prescaler: 8-bit `pcnt`. On `edge`, if `pcnt == PRESCALE-1`, `pcnt` <= 0 and `inc` is asserted. Otherwise `pcnt` increments.
- Counter: on `inc`, `mtime` <= `mtime + 1`, a full 64-bit add with carry. `mtime` wraps from all-ones to 0, with no flag.
- Writes: a write replaces only the addressed 32-bit half. A write to an `mtime` half in the same cycle as `inc` takes priority. The increment for that cycle is dropped, and `pcnt` still resets.
- Reads: when `rd_en` is high, `rd_data` <= the addressed word on the next cycle and `rd_valid` pulses. With no `rd_en`, `rd_data` holds its value.
- Read-during-write to the same address returns the pre-write value.
- Compare: `mtip` <= (`mtime >= mtimecmp`), unsigned, evaluated on current register values every cycle.
- Writing `mtimecmp` above `mtime` clears `mtip` one cycle after the write lands.
- Reset (async): `tick_q`=0, `pcnt`=0, `mtime`=0, `mtimecmp`=`MTIMECMP_RST`, `rd_data`=0, `rd_valid`=0, `mtip`=0.
- Reset asserted mid-count discards all progress. No increment is generated on reset release, even if `tick_src` is high: `tick_q` reloads and the first edge is required.

## Timing
- `tick_src` rises in cycle N, so `edge` is high in N. With `PRESCALE=1`, `mtime` shows the new value in N+1 and `mtip` reflects it in N+2.
- Write in cycle N: register updated in N+1. `mtip` reflects the write in N+2.
- Read latency: 1 cycle, with `rd_valid` aligned to `rd_data`.
- Back-to-back reads every cycle are supported.
- Maximum increment rate is one per two cycles, bounded by the edge-detect rate of the divider output.

## Configuration
- `RV_MTIMER_HALT_EN` defined:
  - Adds input `halt` (1 bit). While `halt` is 1, `inc` is suppressed and `pcnt` holds.
  - `edge` is still tracked, so no spurious increment occurs on `halt` release.
  - Register writes and the compare continue to operate.
- Not defined: no `halt` port, and the timer free-runs.

## Structure
- `rv_mtimer_pkg` holds:
  - address constants `MTIME_LO=0`, `MTIME_HI=1`, `MTIMECMP_LO=2`, `MTIMECMP_HI=3`;
  - `MTIMECMP_RST`;
  - a `mtime_t` 64-bit typedef.
- One sub-module: `tick_edge`, a rising-edge detector with async reset, instanced on `tick_src`.

## Test plan
- Reset, then toggle `tick_src` every 2 cycles, `PRESCALE=1`, for 10 rising edges -> `mtime` reads 10, `mtip`=0, `rd_valid` 1 cycle after `rd_en`.
- `PRESCALE=4`, 12 rising edges -> `mtime`=3, with `pcnt` returning to 0 after each increment.
- Write `mtimecmp`=5 with `mtime`=0, then 5 edges -> `mtip` rises 2 cycles after the 5th edge. Then write `mtimecmp_lo`=100 -> `mtip` drops 2 cycles after the write.
- Write `mtime_lo`=32'hFFFF_FFFF, `mtime_hi`=32'hFFFF_FFFF, then 1 edge -> `mtime`=0 with no flag. With `MTIMECMP_RST`, `mtip` goes 1 then 0.
- Write `mtime_lo`=7 in the same cycle as `inc` -> `mtime` reads 7, not 8. Separately, assert `rst_n`=0 mid-count with `tick_src` held high, then release -> all outputs at reset values and no increment until the next rising edge.
- With `RV_MTIMER_HALT_EN`: hold `halt`=1 across 5 edges -> `mtime` unchanged. Release -> the next edge increments by exactly 1.
